// File: rtl/data_ram_sync_if.sv
// Request/response bus of the synchronous data RAM: a valid/ready request
// channel and a single-cycle response pulse with no backpressure.
interface data_ram_sync_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_ram_sync.sv
// Synchronous byte-addressable little-endian data RAM with LATENCY wait states.
// Optional per-byte even parity with test injection: define DRAM_PARITY_EN.
module data_ram_sync #(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 0
) (
    input  logic           clk,
    input  logic           reset_n,
`ifdef DRAM_PARITY_EN
    input  logic           par_inject,
`endif
    data_ram_sync_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic              accept, do_access, use_cap;

    logic              cap_write, cap_signed;
    logic [1:0]        cap_size;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wdata;

    logic              cur_write, cur_signed;
    logic [1:0]        cur_size;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;

    logic [IDX_W-1:0]  idx;
    logic [3:0]        byte_en;
    logic [7:0]        rb [4];
    logic [31:0]       ld_data;
    logic              rule_err, par_err;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;

    logic [7:0]        mem [DEPTH];
`ifdef DRAM_PARITY_EN
    logic              par_mem [DEPTH];
    logic              cap_inject, cur_inject;
`endif

    assign bus.req_ready  = (state != WAIT);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign accept         = bus.req_valid && bus.req_ready;

    // The access happens on the edge that enters RESP; only WAIT->RESP uses
    // captured fields, a zero-latency accept uses the live bus directly.
    assign do_access = (state_nxt == RESP);
    assign use_cap   = (state == WAIT);

    assign cur_write  = use_cap ? cap_write  : bus.req_write;
    assign cur_size   = use_cap ? cap_size   : bus.req_size;
    assign cur_signed = use_cap ? cap_signed : bus.req_signed;
    assign cur_addr   = use_cap ? cap_addr   : bus.req_addr;
    assign cur_wdata  = use_cap ? cap_wdata  : bus.req_wdata;
`ifdef DRAM_PARITY_EN
    assign cur_inject = use_cap ? cap_inject : par_inject;
`endif

    assign idx = cur_addr[IDX_W-1:0];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, RESP: state_nxt = accept ? ((LATENCY > 0) ? WAIT : RESP) : IDLE;
            WAIT:       if (cnt == 4'd0) state_nxt = RESP;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rule_err = 1'b0;
        byte_en  = 4'b1111;
        unique case (cur_size)
            2'b00:   byte_en  = 4'b0001;
            2'b01:   begin byte_en = 4'b0011; rule_err = cur_addr[0]; end
            2'b10:   rule_err = |cur_addr[1:0];
            default: rule_err = 1'b1;
        endcase
        if ({1'b0, cur_addr} >= (ADDR_W+1)'(DEPTH)) rule_err = 1'b1;
    end

    always_comb begin
        for (int k = 0; k < 4; k++) rb[k] = mem[idx + IDX_W'(k)];
        unique case (cur_size)
            2'b00:   ld_data = {{24{cur_signed & rb[0][7]}}, rb[0]};
            2'b01:   ld_data = {{16{cur_signed & rb[1][7]}}, rb[1], rb[0]};
            default: ld_data = {rb[3], rb[2], rb[1], rb[0]};
        endcase
    end

    always_comb begin
        par_err = 1'b0;
`ifdef DRAM_PARITY_EN
        for (int k = 0; k < 4; k++)
            if (byte_en[k] && (par_mem[idx + IDX_W'(k)] != ^rb[k])) par_err = 1'b1;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            cap_write    <= 1'b0;
            cap_size     <= 2'b00;
            cap_signed   <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= 32'd0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
`ifdef DRAM_PARITY_EN
            cap_inject   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                cap_write  <= bus.req_write;
                cap_size   <= bus.req_size;
                cap_signed <= bus.req_signed;
                cap_addr   <= bus.req_addr;
                cap_wdata  <= bus.req_wdata;
`ifdef DRAM_PARITY_EN
                cap_inject <= par_inject;
`endif
            end
            if (accept && (LATENCY > 0)) cnt <= 4'(LATENCY - 1);
            else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (do_access) begin
                resp_err_q   <= rule_err || (!cur_write && par_err);
                resp_rdata_q <= (rule_err || cur_write) ? 32'd0 : ld_data;
            end
        end
    end

    // NOTE: the storage array has no reset; a reset only aborts the access, it never clears contents.
    always_ff @(posedge clk) begin
        if (do_access && cur_write && !rule_err) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    mem[idx + IDX_W'(k)] <= cur_wdata[8*k +: 8];
`ifdef DRAM_PARITY_EN
                    par_mem[idx + IDX_W'(k)] <= (^cur_wdata[8*k +: 8]) ^ cur_inject;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_data_ram_sync.sv
// Self-checking bench: one LATENCY=0 and one LATENCY=3 instance, directed
// steps plus randomized accesses against a byte-array reference model.
module tb_data_ram_sync;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic par_inj = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  v, w, sg, rdy, rvld, rerr;
    logic [1:0]  sz [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [31:0] rd [2];

    int checks = 0;
    int errors = 0;
    int lat_of [2] = '{0, 3};
    logic [7:0] mdl [2][DEPTH];

    data_ram_sync_if #(.ADDR_W(32)) b0 ();
    data_ram_sync_if #(.ADDR_W(32)) b1 ();

    assign b0.req_valid = v[0];  assign b1.req_valid = v[1];
    assign b0.req_write = w[0];  assign b1.req_write = w[1];
    assign b0.req_signed = sg[0]; assign b1.req_signed = sg[1];
    assign b0.req_size = sz[0];  assign b1.req_size = sz[1];
    assign b0.req_addr = ad[0];  assign b1.req_addr = ad[1];
    assign b0.req_wdata = wd[0]; assign b1.req_wdata = wd[1];
    assign rdy[0] = b0.req_ready;   assign rdy[1] = b1.req_ready;
    assign rvld[0] = b0.resp_valid; assign rvld[1] = b1.resp_valid;
    assign rerr[0] = b0.resp_err;   assign rerr[1] = b1.resp_err;
    assign rd[0] = b0.resp_rdata;   assign rd[1] = b1.resp_rdata;

    data_ram_sync #(.ADDR_W(32), .DEPTH(DEPTH), .LATENCY(0)) u0 (
        .clk(clk), .reset_n(reset_n),
`ifdef DRAM_PARITY_EN
        .par_inject(par_inj),
`endif
        .bus(b0)
    );
    data_ram_sync #(.ADDR_W(32), .DEPTH(DEPTH), .LATENCY(3)) u1 (
        .clk(clk), .reset_n(reset_n),
`ifdef DRAM_PARITY_EN
        .par_inject(par_inj),
`endif
        .bus(b1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: plain byte array, error rules and extension from first principles.
    task automatic model(input int d, input logic wr, input logic [1:0] s, input logic sgn,
                         input logic [31:0] a, input logic [31:0] wdat,
                         output logic e, output logic [31:0] r);
        int n;
        logic [31:0] raw;
        n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        e = (s == 2'd3) || (a >= DEPTH) || (a % n != 0);
        r = 32'd0;
        raw = 32'd0;
        if (!e) begin
            if (wr) begin
                for (int i = 0; i < n; i++) mdl[d][a + i] = wdat[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) raw[8*i +: 8] = mdl[d][a + i];
                r = raw;
                if (sgn && n < 4 && raw[8*n-1]) r = raw | (32'hFFFF_FFFF << (8*n));
            end
        end
    endtask

    // Present a request from #1 after an edge; returns #1 after the accept edge.
    task automatic issue(input int d, input logic wr, input logic [1:0] s, input logic sgn,
                         input logic [31:0] a, input logic [31:0] wdat);
        int tries;
        v[d] = 1'b1; w[d] = wr; sz[d] = s; sg[d] = sgn; ad[d] = a; wd[d] = wdat;
        tries = 0;
        while (!rdy[d] && tries < 20) begin
            @(posedge clk); #1;
            tries++;
        end
        if (tries >= 20) check("issue_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        v[d] = 1'b0;
        wd[d] = $urandom;
        ad[d] = $urandom;
    endtask

    // Called #1 after the accept edge; returns #1 into the response cycle.
    task automatic expect_resp(input int d, input logic e_err, input logic [31:0] e_rd, input string tag);
        for (int c = 0; c < lat_of[d]; c++) begin
            check({tag, "_wait_ready"}, {31'd0, rdy[d]}, 32'd0);
            check({tag, "_wait_valid"}, {31'd0, rvld[d]}, 32'd0);
            @(posedge clk); #1;
        end
        check({tag, "_valid"}, {31'd0, rvld[d]}, 32'd1);
        check({tag, "_err"}, {31'd0, rerr[d]}, {31'd0, e_err});
        check({tag, "_rdata"}, rd[d], e_rd);
    endtask

    task automatic xact(input int d, input logic wr, input logic [1:0] s, input logic sgn,
                        input logic [31:0] a, input logic [31:0] wdat,
                        input logic e_err, input logic [31:0] e_rd, input string tag);
        issue(d, wr, s, sgn, a, wdat);
        expect_resp(d, e_err, e_rd, tag);
        @(posedge clk); #1;
        check({tag, "_pulse"}, {31'd0, rvld[d]}, 32'd0);
    endtask

    // Directed step with literal expectations; the model is only kept in sync.
    task automatic dir(input int d, input logic wr, input logic [1:0] s, input logic sgn,
                       input logic [31:0] a, input logic [31:0] wdat,
                       input logic e_err, input logic [31:0] e_rd, input string tag);
        logic me;
        logic [31:0] mr;
        model(d, wr, s, sgn, a, wdat, me, mr);
        xact(d, wr, s, sgn, a, wdat, e_err, e_rd, tag);
    endtask

    task automatic rnd(input int d, input logic wr, input logic [1:0] s, input logic sgn,
                       input logic [31:0] a, input logic [31:0] wdat, input string tag);
        logic me;
        logic [31:0] mr;
        model(d, wr, s, sgn, a, wdat, me, mr);
        xact(d, wr, s, sgn, a, wdat, me, mr, tag);
    endtask

    logic        r_wr, r_sg;
    logic [1:0]  r_sz;
    logic [31:0] r_a;
    logic        e_a, e_b;
    logic [31:0] x_a, x_b;

    initial begin
        v = '0; w = '0; sg = '0;
        for (int d = 0; d < 2; d++) begin sz[d] = 2'd0; ad[d] = 32'd0; wd[d] = 32'd0; end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", {31'd0, rdy[d]}, 32'd1);
            check("rst_valid", {31'd0, rvld[d]}, 32'd0);
            check("rst_err", {31'd0, rerr[d]}, 32'd0);
            check("rst_rdata", rd[d], 32'd0);
        end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // LATENCY=0 directed
        dir(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, "st_word");
        dir(0, 0, 2'd2, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, "ld_word");
        dir(0, 0, 2'd0, 1, 32'h13, 32'h0, 0, 32'hFFFFFFDE, "ld_byte_s");
        dir(0, 0, 2'd0, 0, 32'h13, 32'h0, 0, 32'h000000DE, "ld_byte_u");
        dir(0, 0, 2'd1, 1, 32'h10, 32'h0, 0, 32'hFFFFBEEF, "ld_half_s");
        dir(0, 0, 2'd1, 0, 32'h10, 32'h0, 0, 32'h0000BEEF, "ld_half_u");
        dir(0, 1, 2'd0, 0, 32'h11, 32'h123456AA, 0, 32'h0, "st_byte");
        dir(0, 0, 2'd2, 0, 32'h10, 32'h0, 0, 32'hDEADAAEF, "ld_partial");
        dir(0, 0, 2'd1, 0, 32'h11, 32'h0, 1, 32'h0, "err_half_mis");
        dir(0, 0, 2'd2, 0, 32'h12, 32'h0, 1, 32'h0, "err_word_mis");
        dir(0, 0, 2'd3, 0, 32'h10, 32'h0, 1, 32'h0, "err_size");
        dir(0, 1, 2'd2, 0, DEPTH, 32'h01020304, 1, 32'h0, "err_range");
        dir(0, 1, 2'd2, 0, 32'h8000_0010, 32'h01020304, 1, 32'h0, "err_range_hi");
        dir(0, 0, 2'd2, 0, 32'h10, 32'h0, 0, 32'hDEADAAEF, "ld_after_err");

        // LATENCY=0 back-to-back: one response per cycle
        model(0, 0, 2'd0, 0, 32'h10, 32'h0, e_a, x_a);
        model(0, 0, 2'd0, 1, 32'h13, 32'h0, e_b, x_b);
        issue(0, 0, 2'd0, 0, 32'h10, 32'h0);
        expect_resp(0, 0, 32'h000000EF, "b2b0_a");
        issue(0, 0, 2'd0, 1, 32'h13, 32'h0);
        expect_resp(0, 0, 32'hFFFFFFDE, "b2b0_b");
        @(posedge clk); #1;
        check("b2b0_pulse", {31'd0, rvld[0]}, 32'd0);

        // LATENCY=3 timing and back-to-back accept in the RESP cycle
        dir(1, 1, 2'd2, 0, 32'h20, 32'h11223344, 0, 32'h0, "l3_st");
        dir(1, 0, 2'd2, 0, 32'h20, 32'h0, 0, 32'h11223344, "l3_ld");
        issue(1, 0, 2'd1, 0, 32'h20, 32'h0);
        expect_resp(1, 0, 32'h00003344, "l3_b2b_a");
        issue(1, 0, 2'd0, 0, 32'h21, 32'h0);
        expect_resp(1, 0, 32'h00000033, "l3_b2b_b");
        @(posedge clk); #1;
        check("l3_b2b_pulse", {31'd0, rvld[1]}, 32'd0);

        // Reset during WAIT of a store: must abort without committing
        issue(1, 1, 2'd2, 0, 32'h20, 32'h55667788);
        check("abort_in_wait", {31'd0, rdy[1]}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("abort_ready", {31'd0, rdy[1]}, 32'd1);
        check("abort_valid", {31'd0, rvld[1]}, 32'd0);
        check("abort_err", {31'd0, rerr[1]}, 32'd0);
        check("abort_rdata", rd[1], 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("abort_no_resp", {31'd0, rvld[1]}, 32'd0);
        end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        dir(1, 0, 2'd2, 0, 32'h20, 32'h0, 0, 32'h11223344, "abort_old_data");

        // Randomized accesses against the model
        for (int d = 0; d < 2; d++)
            for (int a = 32'h100; a < 32'h120; a += 4)
                rnd(d, 1, 2'd2, 0, a, $urandom, "prefill");
        for (int i = 0; i < 80; i++) begin
            r_wr = 1'($urandom_range(0, 1));
            r_sg = 1'($urandom_range(0, 1));
            r_sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) r_a = (i % 4 == 0) ? 32'hFFFF_FFF0 : DEPTH + $urandom_range(0, 15);
            else r_a = 32'h100 + $urandom_range(0, 31);
            rnd(i % 2, r_wr, r_sz, r_sg, r_a, $urandom, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
